onchip_memory_dp: RTL



---
 rtl/onchip_memory_dp.sv | 118 +++++++++++
 1 files changed

// File: rtl/onchip_memory_dp.sv
// onchip_memory_dp: dual-port byte-enable RAM with cross-port write forwarding and a 1-2 cycle read pipeline.
module onchip_memory_dp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_parity_err,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_parity_err,
  input  logic                    parity_inject
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int L = READ_LATENCY - 1;
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8 in 8..128");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] a [2];
  logic [NB-1:0]         be [2];
  logic [DATA_WIDTH-1:0] wd [2];
  logic [1:0]            we, re, perr;
  logic [DATA_WIDTH-1:0] fwd [2];
  logic [1:0]            v [READ_LATENCY];
  logic [1:0]            e [READ_LATENCY];
  logic [DATA_WIDTH-1:0] d [READ_LATENCY][2];
  always_comb begin
    a  = '{s1_address, s2_address};
    be = '{s1_byteenable, s2_byteenable};
    wd = '{s1_writedata, s2_writedata};
    we = {s2_chipselect & s2_write, s1_chipselect & s1_write} & {2{!reset}};
    re = {s2_chipselect & s2_read & !s2_write, s1_chipselect & s1_read & !s1_write};
  end
`ifdef ONCHIP_MEMORY_DP_PARITY_EN
  logic [NB-1:0] par [2**ADDR_WIDTH];
  logic [NB-1:0] fpar [2];
`else
  logic unused_inject;
  assign unused_inject = parity_inject;
`endif
  always_ff @(posedge clk)
    for (int p = 1; p >= 0; p--)
      for (int b = 0; b < NB; b++)
        if (we[p] && be[p][b]) begin
          mem[a[p]][8*b +: 8] <= wd[p][8*b +: 8];
`ifdef ONCHIP_MEMORY_DP_PARITY_EN
          par[a[p]][b] <= ^wd[p][8*b +: 8] ^ parity_inject;
`endif
        end
  always_comb
    for (int p = 0; p < 2; p++) begin
      fwd[p] = mem[a[p]];
`ifdef ONCHIP_MEMORY_DP_PARITY_EN
      fpar[p] = par[a[p]];
`endif
      for (int q = 1; q >= 0; q--)
        for (int b = 0; b < NB; b++)
          if (we[q] && be[q][b] && a[q] == a[p]) begin
            fwd[p][8*b +: 8] = wd[q][8*b +: 8];
`ifdef ONCHIP_MEMORY_DP_PARITY_EN
            fpar[p][b] = ^wd[q][8*b +: 8] ^ parity_inject;
`endif
          end
      perr[p] = 1'b0;
`ifdef ONCHIP_MEMORY_DP_PARITY_EN
      for (int b = 0; b < NB; b++)
        perr[p] = perr[p] | ((^fwd[p][8*b +: 8]) != fpar[p][b]);
`endif
    end
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int k = 0; k < READ_LATENCY; k++) begin
        v[k] <= '0;
        e[k] <= '0;
        for (int p = 0; p < 2; p++) d[k][p] <= '0;
      end
    else
      for (int p = 0; p < 2; p++) begin
        v[0][p] <= re[p];
        if (re[p]) begin
          d[0][p] <= fwd[p];
          e[0][p] <= perr[p];
        end
        for (int k = 1; k < READ_LATENCY; k++) begin
          v[k][p] <= v[k-1][p];
          if (v[k-1][p]) begin
            d[k][p] <= d[k-1][p];
            e[k][p] <= e[k-1][p];
          end
        end
      end
  assign s1_readdata      = d[L][0];
  assign s2_readdata      = d[L][1];
  assign s1_readdatavalid = v[L][0];
  assign s2_readdatavalid = v[L][1];
  assign s1_parity_err    = v[L][0] & e[L][0];
  assign s2_parity_err    = v[L][1] & e[L][1];
endmodule
